// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the fetch front end.
package cpu_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetchEntry_t;

  function automatic logic [XLEN-1:0] alignPC(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {PC4, PC, Inst} entries; flush empties it in one cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     iClkCPU,
  input  logic                     iRST,
  input  logic                     iPush,
  input  logic [3*XLEN-1:0]        iData,
  input  logic                     iPop,
  input  logic                     iFlush,
  output logic [3*XLEN-1:0]        oHead,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oFull,
  output logic                     oEmpty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [3*XLEN-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [PTR_W:0]    count;
  logic              doPush, doPop;

  assign oFull  = (count == (PTR_W+1)'(DEPTH));
  assign oEmpty = (count == '0);
  assign oCount = count;
  assign oHead  = mem[rdPtr];
  assign doPush = iPush && !oFull;
  assign doPop  = iPop && !oEmpty;

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (iFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iData;
        wrPtr      <= wrPtr + PTR_W'(1);
      end
      if (doPop) rdPtr <= rdPtr + PTR_W'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // The upstream credit scheme must never push into a full FIFO.
  assert property (@(posedge iClkCPU) disable iff (iRST) !(iPush && oFull && !iFlush));
endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: PC, ROM requests with credit control, redirect flush, prefetch FIFO.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic                     iClkCPU,
  input  logic                     iRST,
  output logic                     oImemReq,
  output logic [ADDR_W-3:0]        oImemAddr,
  input  logic [31:0]              iImemData,
  input  logic                     iRedirect,
  input  logic [31:0]              iRedirectPC,
  output logic                     oValid,
  input  logic                     iReady,
  output logic [31:0]              oInst,
  output logic [31:0]              oPC,
  output logic [31:0]              oPC4,
  output logic [$clog2(DEPTH):0]   oCount
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      pcQ, pcD, reqPCQ;
  logic             inflightQ;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   used;
  logic             push, pop, empty, unusedFull;
  logic [95:0]      pushData, head;

  // Occupancy plus the outstanding read bounds how many entries may still arrive.
  assign used      = {1'b0, count} + {{CNT_W{1'b0}}, inflightQ};
  assign oImemReq  = !iRST && !iRedirect && (used < (CNT_W+1)'(DEPTH));
  assign oImemAddr = pcQ[ADDR_W-1:2];

  assign push     = inflightQ && !iRedirect;
  assign oValid   = !empty && !iRedirect;
  assign pop      = oValid && iReady;
  assign pushData = {reqPCQ + 32'd4, reqPCQ, iImemData};
  assign {oPC4, oPC, oInst} = head;
  assign oCount   = count;

  always_comb begin
    pcD = pcQ;
    if (iRedirect)     pcD = alignPC(iRedirectPC);
    else if (oImemReq) pcD = pcQ + 32'd4;
  end

  always_ff @(posedge iClkCPU or posedge iRST) begin
    if (iRST) begin
      pcQ       <= RESET_PC;
      reqPCQ    <= '0;
      inflightQ <= 1'b0;
    end else begin
      pcQ       <= pcD;
      inflightQ <= oImemReq;
      if (oImemReq) reqPCQ <= pcQ;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .iClkCPU (iClkCPU),
    .iRST    (iRST),
    .iPush   (push),
    .iData   (pushData),
    .iPop    (pop),
    .iFlush  (iRedirect),
    .oHead   (head),
    .oCount  (count),
    .oFull   (unusedFull),
    .oEmpty  (empty)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue with an address-indexed ROM and an output scoreboard.
module tb_fetch_queue;
  logic        iClkCPU, iRST, oImemReq, iRedirect, oValid, iReady;
  logic [7:0]  oImemAddr;
  logic [31:0] iImemData, iRedirectPC, oInst, oPC, oPC4;
  logic [2:0]  oCount;

  int nChecks = 0;
  int nPass   = 0;
  int nPops   = 0;
  int nReq;
  logic [95:0] expQ[$];

  fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0040_0000),
    .ADDR_W   (10)
  ) dut (
    .iClkCPU     (iClkCPU),
    .iRST        (iRST),
    .oImemReq    (oImemReq),
    .oImemAddr   (oImemAddr),
    .iImemData   (iImemData),
    .iRedirect   (iRedirect),
    .iRedirectPC (iRedirectPC),
    .oValid      (oValid),
    .iReady      (iReady),
    .oInst       (oInst),
    .oPC         (oPC),
    .oPC4        (oPC4),
    .oCount      (oCount)
  );

  initial begin
    iClkCPU = 1'b0;
    forever #5 iClkCPU = ~iClkCPU;
  end

  function automatic logic [31:0] romWord(input logic [7:0] a);
    return {8'hA5, 8'h3C, a, ~a};
  endfunction

  // ROM answers one cycle after the address is presented.
  always @(posedge iClkCPU) iImemData <= romWord(oImemAddr);

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic expectFrom(input logic [31:0] pc, input int n);
    logic [31:0] p;
    expQ.delete();
    for (int i = 0; i < n; i++) begin
      p = pc + 32'(4 * i);
      expQ.push_back({p + 32'd4, p, romWord(p[9:2])});
    end
  endtask

  // Evaluate the handshake after inputs settle, then advance to the next negedge.
  task automatic tick();
    logic [95:0] e;
    #1;
    if (oValid && iReady) begin
      nPops++;
      if (expQ.size() == 0) checkVal("unexpected_pop", oPC, 32'hFFFF_FFFF);
      else begin
        e = expQ.pop_front();
        checkVal("pop_pc", oPC, e[63:32]);
        checkVal("pop_pc4", oPC4, e[95:64]);
        checkVal("pop_inst", oInst, e[31:0]);
      end
    end
    @(negedge iClkCPU);
  endtask

  task automatic doReset(input logic rdy);
    iRST = 1'b1;
    iRedirect = 1'b0;
    iRedirectPC = '0;
    iReady = rdy;
    expQ.delete();
    tick();
    tick();
    iRST = 1'b0;
  endtask

  initial begin
    iRST = 1'b1;
    iRedirect = 1'b0;
    iRedirectPC = '0;
    iReady = 1'b0;
    @(negedge iClkCPU);
    #1;
    checkVal("rst_valid", 32'(oValid), 0);
    checkVal("rst_req", 32'(oImemReq), 0);
    checkVal("rst_count", 32'(oCount), 0);
    checkVal("rst_inst", oInst, 0);
    checkVal("rst_pc", oPC, 0);
    checkVal("rst_pc4", oPC4, 0);

    // Streaming with iReady held high
    doReset(1'b1);
    expectFrom(32'h0040_0000, 40);
    #1;
    checkVal("s_req0", 32'(oImemReq), 1);
    checkVal("s_addr0", 32'(oImemAddr), 32'h0);
    checkVal("s_valid0", 32'(oValid), 0);
    tick();
    checkVal("s_addr1", 32'(oImemAddr), 32'h1);
    checkVal("s_valid1", 32'(oValid), 0);
    tick();
    checkVal("s_addr2", 32'(oImemAddr), 32'h2);
    checkVal("s_valid2", 32'(oValid), 1);
    checkVal("s_first_pc", oPC, 32'h0040_0000);
    checkVal("s_first_pc4", oPC4, 32'h0040_0004);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkVal("s_stream_valid", 32'(oValid), 1);
    end

    // Backpressure from reset, then drain
    doReset(1'b0);
    nReq = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (oImemReq) nReq++;
      tick();
    end
    checkVal("bp_req_count", 32'(nReq), 4);
    checkVal("bp_req_idle", 32'(oImemReq), 0);
    checkVal("bp_count", 32'(oCount), 4);
    expectFrom(32'h0040_0000, 40);
    nPops = 0;
    iReady = 1'b1;
    #1;
    checkVal("bp_no_req_at_pop", 32'(oImemReq), 0);
    tick();
    checkVal("bp_req_resume", 32'(oImemReq), 1);
    checkVal("bp_resume_addr", 32'(oImemAddr), 32'h4);
    for (int k = 0; k < 6; k++) tick();
    checkVal("bp_drained", 32'(nPops >= 4), 1);

    // Redirect while count=3 with a read in flight
    doReset(1'b0);
    for (int k = 0; k < 4; k++) tick();
    checkVal("r1_count_before", 32'(oCount), 3);
    iRedirect = 1'b1;
    iRedirectPC = 32'h0040_0103;
    iReady = 1'b1;
    expectFrom(32'h0040_0100, 40);
    #1;
    checkVal("r1_valid_during", 32'(oValid), 0);
    checkVal("r1_req_during", 32'(oImemReq), 0);
    tick();
    iRedirect = 1'b0;
    #1;
    checkVal("r1_count_after", 32'(oCount), 0);
    checkVal("r1_req_after", 32'(oImemReq), 1);
    checkVal("r1_addr_after", 32'(oImemAddr), 32'h40);
    checkVal("r1_valid_r1", 32'(oValid), 0);
    tick();
    checkVal("r1_valid_r2", 32'(oValid), 0);
    tick();
    checkVal("r1_valid_r3", 32'(oValid), 1);
    checkVal("r1_target_pc", oPC, 32'h0040_0100);
    for (int k = 0; k < 5; k++) tick();

    // Redirect in the same cycle as iReady with count=2
    doReset(1'b0);
    for (int k = 0; k < 3; k++) tick();
    checkVal("r2_count_before", 32'(oCount), 2);
    iReady = 1'b1;
    iRedirect = 1'b1;
    iRedirectPC = 32'h0040_0200;
    expectFrom(32'h0040_0200, 40);
    nPops = 0;
    #1;
    checkVal("r2_no_handshake", 32'(oValid && iReady), 0);
    tick();
    iRedirect = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checkVal("r2_new_path_pops", 32'(nPops >= 5), 1);

    // Back-to-back redirects: the second target wins
    iRedirect = 1'b1;
    iRedirectPC = 32'h0040_0040;
    expQ.delete();
    tick();
    iRedirectPC = 32'h0040_0080;
    expectFrom(32'h0040_0080, 40);
    tick();
    iRedirect = 1'b0;
    tick();
    tick();
    checkVal("r3_valid", 32'(oValid), 1);
    checkVal("r3_first_pc", oPC, 32'h0040_0080);
    for (int k = 0; k < 4; k++) tick();

    // Asynchronous reset mid-stream with count=2
    doReset(1'b0);
    for (int k = 0; k < 3; k++) tick();
    checkVal("ar_count_before", 32'(oCount), 2);
    #2;
    iRST = 1'b1;
    #1;
    checkVal("ar_valid", 32'(oValid), 0);
    checkVal("ar_req", 32'(oImemReq), 0);
    checkVal("ar_count", 32'(oCount), 0);
    checkVal("ar_pc", oPC, 0);
    checkVal("ar_inst", oInst, 0);
    checkVal("ar_pc4", oPC4, 0);
    expQ.delete();
    tick();
    iRST = 1'b0;
    iReady = 1'b1;
    expectFrom(32'h0040_0000, 40);
    #1;
    checkVal("ar_restart_req", 32'(oImemReq), 1);
    checkVal("ar_restart_addr", 32'(oImemAddr), 32'h0);
    for (int k = 0; k < 6; k++) tick();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
